// File: rtl/corevx_ifetch_port_pkg.sv
// corevx_ifetch_port_pkg: cache command/response codes and local types for the instruction fetch port.
package corevx_ifetch_port_pkg;
    localparam logic [3:0] CACHE_CMD_NONE       = 4'd0;
    localparam logic [3:0] CACHE_CMD_EXECUTE    = 4'd1;
    localparam logic [3:0] CACHE_CMD_FLUSH_ALL  = 4'd2;
    localparam logic [3:0] CACHE_RESPONSE_IDLE        = 4'd0;
    localparam logic [3:0] CACHE_RESPONSE_WAIT        = 4'd1;
    localparam logic [3:0] CACHE_RESPONSE_DONE        = 4'd2;
    localparam logic [3:0] CACHE_RESPONSE_MISSALIGNED = 4'd3;
    localparam logic [3:0] CACHE_RESPONSE_ACCESSFAULT = 4'd4;
    localparam logic [3:0] CACHE_RESPONSE_PAGEFAULT   = 4'd5;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_REFILL} state_t;

    // Unsigned offset test covers both the below-base and above-top cases.
    function automatic logic in_region(input logic [31:0] addr, input logic [31:0] base, input logic [31:0] size);
        return (addr - base) < size;
    endfunction
endpackage

// File: rtl/corevx_ifetch_linebuf.sv
// corevx_ifetch_linebuf: single-line buffer with tag, valid bit, beat-indexed write and combinational read.
module corevx_ifetch_linebuf #(
    parameter int LINE_WORDS = 4,
    parameter int TW = 28
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          set_valid,
    input  logic                          tag_load,
    input  logic [TW-1:0]                 tag_in,
    input  logic                          wr_en,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_idx,
    input  logic [31:0]                   wr_data,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_idx,
    output logic [31:0]                   rd_data,
    output logic [TW-1:0]                 tag,
    output logic                          valid
);
    logic [31:0] words [LINE_WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag   <= '0;
            valid <= 1'b0;
        end else begin
            valid <= clear ? 1'b0 : set_valid ? 1'b1 : valid;
            if (tag_load) tag <= tag_in;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) words[wr_idx] <= wr_data;
    end

    assign rd_data = words[rd_idx];
endmodule

// File: rtl/corevx_ifetch_port.sv
// corevx_ifetch_port: instruction-side cache command responder backed by a one-line buffer
// refilled over a word-burst memory bus.
module corevx_ifetch_port
    import corevx_ifetch_port_pkg::*;
#(
    parameter int          LINE_WORDS = 4,
    parameter logic [31:0] MEM_BASE   = 32'h0000_0000,
    parameter logic [31:0] MEM_SIZE   = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  c_cmd,
    input  logic [31:0] c_address,
    output logic [3:0]  c_response,
    output logic [31:0] c_load_data,
    output logic        c_reset_done,
    output logic        m_req,
    output logic [31:0] m_addr,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    input  logic        m_rerr,
    input  logic        m_rlast
);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int LB = OW + 2;
    localparam int TW = 32 - LB;

    state_t        state;
    logic [OW-1:0] cnt;
    logic          err;
    logic [TW-1:0] tag;
    logic          valid;
    logic [31:0]   rd_data;
    logic          is_exec, is_flush, misal, oor, hit, miss, last, err_now, same;

    always_comb begin
        is_exec  = c_cmd == CACHE_CMD_EXECUTE;
        is_flush = c_cmd == CACHE_CMD_FLUSH_ALL;
        misal    = c_address[1:0] != 2'b00;
        oor      = !in_region(c_address, MEM_BASE, MEM_SIZE);
        hit      = valid && tag == c_address[31:LB];
        miss     = state == ST_IDLE && is_exec && !misal && !oor && !hit;
        last     = state == ST_REFILL && m_rvalid && m_rlast;
        err_now  = err || m_rerr;
        same     = c_address[31:LB] == m_addr[31:LB];
    end

    corevx_ifetch_linebuf #(.LINE_WORDS(LINE_WORDS), .TW(TW)) u_linebuf (
        .clk       (clk),
        .rst       (rst),
        .clear     (miss || (state == ST_IDLE && is_flush)),
        .set_valid (last && !err_now),
        .tag_load  (miss),
        .tag_in    (c_address[31:LB]),
        .wr_en     (state == ST_REFILL && m_rvalid),
        .wr_idx    (cnt),
        .wr_data   (m_rdata),
        .rd_idx    (c_address[LB-1:2]),
        .rd_data   (rd_data),
        .tag       (tag),
        .valid     (valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_INIT;
            c_response   <= CACHE_RESPONSE_IDLE;
            c_load_data  <= '0;
            c_reset_done <= 1'b0;
            m_req        <= 1'b0;
            m_addr       <= '0;
            cnt          <= '0;
            err          <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    state        <= ST_IDLE;
                    c_reset_done <= 1'b1;
                    c_response   <= CACHE_RESPONSE_IDLE;
                end
                ST_IDLE: begin
                    c_response <= !is_exec ? (is_flush ? CACHE_RESPONSE_DONE : CACHE_RESPONSE_IDLE) :
                                  misal ? CACHE_RESPONSE_MISSALIGNED :
                                  oor ? CACHE_RESPONSE_ACCESSFAULT :
                                  hit ? CACHE_RESPONSE_DONE : CACHE_RESPONSE_WAIT;
                    if (is_exec && !misal && !oor && hit) c_load_data <= rd_data;
                    if (miss) begin
                        state  <= ST_REFILL;
                        m_req  <= 1'b1;
                        m_addr <= {c_address[31:LB], {LB{1'b0}}};
                        cnt    <= '0;
                        err    <= 1'b0;
                    end
                end
                default: begin
                    // A counter wrap before the last beat means the burst was too long.
                    if (m_rvalid) begin
                        cnt <= cnt + 1'b1;
                        if (m_rerr || (&cnt && !m_rlast)) err <= 1'b1;
                    end
                    c_response <= CACHE_RESPONSE_WAIT;
                    if (last) begin
                        state      <= ST_IDLE;
                        m_req      <= 1'b0;
                        c_response <= !is_exec ? (is_flush ? CACHE_RESPONSE_WAIT : CACHE_RESPONSE_IDLE) :
                                      !same ? CACHE_RESPONSE_WAIT :
                                      err_now ? CACHE_RESPONSE_ACCESSFAULT : CACHE_RESPONSE_DONE;
                        if (is_exec && same && !err_now)
                            c_load_data <= (c_address[LB-1:2] == cnt) ? m_rdata : rd_data;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_corevx_ifetch_port.sv
// tb_corevx_ifetch_port: directed scoreboard bench for the instruction fetch port.
module tb_corevx_ifetch_port;
    import corevx_ifetch_port_pkg::*;

    typedef struct {
        logic [3:0]  resp;
        logic [31:0] data;
        logic        mreq;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  c_cmd = CACHE_CMD_NONE;
    logic [31:0] c_address = '0;
    logic [3:0]  c_response;
    logic [31:0] c_load_data;
    logic        c_reset_done;
    logic        m_req;
    logic [31:0] m_addr;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        m_rerr = 1'b0;
    logic        m_rlast = 1'b0;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] ld_model = '0;
    exp_t        sb[$];

    localparam logic [3:0] NO = CACHE_CMD_NONE;
    localparam logic [3:0] EX = CACHE_CMD_EXECUTE;
    localparam logic [3:0] FL = CACHE_CMD_FLUSH_ALL;
    localparam logic [3:0] R_IDLE = CACHE_RESPONSE_IDLE;
    localparam logic [3:0] R_WAIT = CACHE_RESPONSE_WAIT;
    localparam logic [3:0] R_DONE = CACHE_RESPONSE_DONE;
    localparam logic [3:0] R_MIS  = CACHE_RESPONSE_MISSALIGNED;
    localparam logic [3:0] R_AF   = CACHE_RESPONSE_ACCESSFAULT;

    corevx_ifetch_port dut (
        .clk          (clk),
        .rst          (rst),
        .c_cmd        (c_cmd),
        .c_address    (c_address),
        .c_response   (c_response),
        .c_load_data  (c_load_data),
        .c_reset_done (c_reset_done),
        .m_req        (m_req),
        .m_addr       (m_addr),
        .m_rvalid     (m_rvalid),
        .m_rdata      (m_rdata),
        .m_rerr       (m_rerr),
        .m_rlast      (m_rlast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, want);
        end
    endtask

    // One clock: drive inputs, push the expected post-edge outputs, then pop and compare.
    task automatic step(input logic [3:0] cmd, input logic [31:0] addr, input logic rv, input logic [31:0] rd,
                        input logic re, input logic rl, input logic [3:0] er, input logic [31:0] ed, input logic em);
        exp_t e;
        c_cmd = cmd; c_address = addr; m_rvalid = rv; m_rdata = rd; m_rerr = re; m_rlast = rl;
        if (er == R_DONE && cmd == EX) ld_model = ed;
        sb.push_back('{resp: er, data: ld_model, mreq: em});
        @(posedge clk); #1;
        e = sb.pop_front();
        chk($sformatf("resp@%h", addr), 32'(c_response), 32'(e.resp));
        chk($sformatf("data@%h", addr), c_load_data, e.data);
        chk($sformatf("mreq@%h", addr), 32'(m_req), 32'(e.mreq));
        m_rvalid = 1'b0; m_rerr = 1'b0; m_rlast = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_done_in_rst", 32'(c_reset_done), 0);
        chk("resp_in_rst", 32'(c_response), 32'(R_IDLE));
        chk("mreq_in_rst", 32'(m_req), 0);
        rst = 1'b0;
        step(EX, 32'h2000, 0, 0, 0, 0, R_IDLE, 0, 0);
        chk("reset_done_after", 32'(c_reset_done), 1);
        // cold miss then hits
        step(EX, 32'h2000, 0, 0, 0, 0, R_WAIT, 0, 1);
        chk("m_addr_cold", m_addr, 32'h2000);
        step(EX, 32'h2000, 1, 32'h13, 0, 0, R_WAIT, 0, 1);
        step(EX, 32'h2000, 1, 32'h93, 0, 0, R_WAIT, 0, 1);
        step(EX, 32'h2000, 1, 32'h113, 0, 0, R_WAIT, 0, 1);
        step(EX, 32'h2000, 1, 32'h193, 0, 1, R_DONE, 32'h13, 0);
        step(EX, 32'h2004, 0, 0, 0, 0, R_DONE, 32'h93, 0);
        step(EX, 32'h2008, 0, 0, 0, 0, R_DONE, 32'h113, 0);
        // faults
        step(EX, 32'h2002, 0, 0, 0, 0, R_MIS, 0, 0);
        step(EX, 32'h0002_0000, 0, 0, 0, 0, R_AF, 0, 0);
        // flush then refill with an error beat
        step(FL, 32'h0, 0, 0, 0, 0, R_DONE, 0, 0);
        step(EX, 32'h2000, 0, 0, 0, 0, R_WAIT, 0, 1);
        chk("m_addr_after_flush", m_addr, 32'h2000);
        step(EX, 32'h2000, 1, 32'h13, 0, 0, R_WAIT, 0, 1);
        step(EX, 32'h2000, 1, 32'h93, 0, 0, R_WAIT, 0, 1);
        step(EX, 32'h2000, 1, 32'h113, 1, 0, R_WAIT, 0, 1);
        step(EX, 32'h2000, 1, 32'h193, 0, 1, R_AF, 0, 0);
        // errored line stays invalid; last-word request is forwarded from the final beat
        step(EX, 32'h2000, 0, 0, 0, 0, R_WAIT, 0, 1);
        step(EX, 32'h200C, 1, 32'h13, 0, 0, R_WAIT, 0, 1);
        step(EX, 32'h200C, 1, 32'h93, 0, 0, R_WAIT, 0, 1);
        step(EX, 32'h200C, 1, 32'h113, 0, 0, R_WAIT, 0, 1);
        step(EX, 32'h200C, 1, 32'h193, 0, 1, R_DONE, 32'h193, 0);
        step(EX, 32'h2004, 0, 0, 0, 0, R_DONE, 32'h93, 0);
        // reset in the middle of a refill
        step(FL, 32'h0, 0, 0, 0, 0, R_DONE, 0, 0);
        step(EX, 32'h2000, 0, 0, 0, 0, R_WAIT, 0, 1);
        step(EX, 32'h2000, 1, 32'h55, 0, 0, R_WAIT, 0, 1);
        rst = 1'b1;
        #1;
        chk("mreq_async_drop", 32'(m_req), 0);
        @(posedge clk); #1;
        chk("reset_done_mid", 32'(c_reset_done), 0);
        chk("resp_mid_rst", 32'(c_response), 32'(R_IDLE));
        ld_model = '0;
        rst = 1'b0;
        step(NO, 32'h0, 1, 32'h77, 0, 1, R_IDLE, 0, 0);
        chk("reset_done_rerelease", 32'(c_reset_done), 1);
        step(EX, 32'h2000, 0, 0, 0, 0, R_WAIT, 0, 1);
        chk("m_addr_refetch", m_addr, 32'h2000);
        step(EX, 32'h2004, 1, 32'hA0, 0, 0, R_WAIT, 0, 1);
        step(EX, 32'h2004, 1, 32'hA1, 0, 0, R_WAIT, 0, 1);
        step(EX, 32'h2004, 1, 32'hA2, 0, 0, R_WAIT, 0, 1);
        step(EX, 32'h2004, 1, 32'hA3, 0, 1, R_DONE, 32'hA1, 0);
        step(NO, 32'h0, 0, 0, 0, 0, R_IDLE, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/corevx_ifetch_port.md
# corevx_ifetch_port

Responder end of the CoreVX cache command interface for the instruction side. It accepts EXECUTE and FLUSH_ALL commands from the fetch stage, serves words from a single-line buffer and refills that buffer from a word-burst memory bus. It reports misalignment and access faults, and drives the reset-done handshake. It sits between corevx_fetch and the instruction memory/interconnect as a minimal stand-in for the full cache.

## Interface
- LINE_WORDS, 4: words per buffered line; power of two, 2..16.
- MEM_BASE, 32'h0000_0000: lowest executable byte address.
- MEM_SIZE, 32'h0001_0000: executable region size in bytes; power of two, MEM_BASE aligned to it.
- clk  in  1  sole clock.
- rst  in  1  reset; one clock, reset is asynchronous and active-high.
- c_cmd  in  4  command; CACHE_CMD_NONE / _EXECUTE / _FLUSH_ALL from corevx_cache.svh; other codes treated as NONE.
- c_address  in  32  byte address of EXECUTE.
- c_response  out  4  registered response; CACHE_RESPONSE_* codes.
- c_load_data  out  32  instruction word, valid when c_response==DONE.
- c_reset_done  out  1  high once the port accepts commands.
- m_req  out  1  burst request, held high until the last beat.
- m_addr  out  32  line-aligned burst start address, stable while m_req.
- m_rvalid  in  1  beat valid; beats return in increasing word order.
- m_rdata  in  32  beat data.
- m_rerr  in  1  beat error, qualified by m_rvalid.
- m_rlast  in  1  final beat, qualified by m_rvalid.

## Operation
- States: INIT, IDLE, REFILL.
- INIT is entered on reset. The next clk edge after rst deasserts moves to IDLE and sets c_reset_done=1. Commands in INIT are ignored.
- Line buffer holds tag (address bits above the line offset), a valid bit and LINE_WORDS words. It is cleared by reset and by FLUSH_ALL.
- IDLE, EXECUTE classification, evaluated in priority order:
  - c_address[1:0]!=0: respond MISSALIGNED.
  - Address outside [MEM_BASE, MEM_BASE+MEM_SIZE): respond ACCESSFAULT; no bus activity.
  - Tag match with valid set: respond DONE with the buffered word.
  - Otherwise: respond WAIT, invalidate the line, latch the line address, assert m_req, go to REFILL.
- IDLE, FLUSH_ALL: clear valid; respond DONE.
- IDLE, NONE: respond IDLE.
- REFILL:
  - Each m_rvalid beat writes the word at the beat counter and increments the counter.
  - Any m_rerr sets a sticky error flag.
  - Every cycle before the last beat responds WAIT, regardless of c_cmd.
  - On the m_rlast beat:
    - Clear m_req and return to IDLE.
    - Set valid only if the error flag is clear.
    - Answer that cycle's c_cmd: EXECUTE to the refilled line gives DONE with the word, forwarded from the incoming beat if it is the last word; EXECUTE with an error gives ACCESSFAULT; EXECUTE to a different line gives WAIT, which is re-evaluated in IDLE next cycle; FLUSH_ALL gives WAIT; NONE gives IDLE.
- PAGEFAULT is never produced.
- c_load_data holds its previous value when the response is not DONE.

## Timing
- All outputs are registered.
- Reset values: c_response=IDLE, c_load_data=0, c_reset_done=0, m_req=0, m_addr=0, valid=0, state INIT.
- Hit latency: command in cycle N, DONE in cycle N+1. Back-to-back hits give one DONE per cycle.
- Miss: WAIT from N+1. m_req rises in N+1. The last beat in cycle M gives DONE or ACCESSFAULT in M+1.
- FLUSH_ALL and fault responses last exactly one cycle.
- The initiator re-issues the same command while it sees WAIT. The port does not depend on this, because the refill always completes.
- rst mid-refill: m_req drops asynchronously and valid clears. Stray beats after reset are ignored.
- m_rlast without m_rvalid is ignored. A beat counter overflow before m_rlast wraps and sets the error flag.

## Structure
- CACHE_CMD_* and CACHE_RESPONSE_* stay in the shared corevx_cache.svh.
- The state encoding is local to the block.
- One sub-module, corevx_ifetch_linebuf: tag, valid, word array, a write port indexed by beat, and a combinational read port indexed by c_address word offset.

## Test plan
- Reset release: c_reset_done is 0 during rst and 1 one edge after. c_response=IDLE throughout.
- Cold miss then hit: EXECUTE 0x2000 gives WAIT and m_addr=0x2000. Beats 0x13,0x93,0x113,0x193 give DONE with 0x13. EXECUTE 0x2004 next cycle gives DONE 0x93 with no m_req.
- EXECUTE 0x2002 gives MISSALIGNED. EXECUTE 0x0002_0000 gives ACCESSFAULT. m_req stays 0 in both cases.
- Refill with m_rerr on beat 2: response ACCESSFAULT after m_rlast. A repeat EXECUTE 0x2000 misses again.
- FLUSH_ALL after a filled line: DONE in one cycle. The next EXECUTE 0x2000 gives WAIT and a new burst.
- rst asserted in the middle of a refill: m_req drops immediately. After release, EXECUTE 0x2000 misses and refetches.
